if_map_writer: RTL and testbench

//  Producer side of the IF-map scratchpad: the SRAM write port that the conv datapath's read path consumes.

---
 rtl/if_map_writer_pkg.sv | 16 +
 rtl/if_map_writer_circ_ptr.sv | 37 +++
 rtl/if_map_writer.sv | 138 +++++++++++++
 tb/tb_if_map_writer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_map_writer_pkg.sv
// rtl/if_map_writer_pkg.sv - shared IF-map scratchpad state encoding and default geometry
package if_map_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  localparam int unsigned DEF_ADDR_WIDTH  = 4;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_FILTER_SIZE = 4;
  localparam int unsigned DEF_STRIDE_SIZE = 2;

endpackage

// File: rtl/if_map_writer_circ_ptr.sv
// rtl/if_map_writer_circ_ptr.sv - wrapping circular-buffer pointer with clear and step-by-N advance
module if_map_writer_circ_ptr #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  localparam logic [WIDTH-1:0] STEP_C = WIDTH'(STEP);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  // Window size is a power of two, so natural overflow gives the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + STEP_C;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/if_map_writer.sv
// rtl/if_map_writer.sv - IF-map scratchpad producer: stream-to-SRAM writer with circular window tracking
module if_map_writer
  import if_map_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 2 ** ADDR_WIDTH,
  parameter int unsigned FILTER_SIZE = DEF_FILTER_SIZE,
  parameter int unsigned STRIDE_SIZE = DEF_STRIDE_SIZE,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  total_len_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  row_done_i,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] din_o,
  output logic                  wen_o,
  output logic                  chip_en_o,
  output logic [ADDR_WIDTH-1:0] head_addr_o,
  output logic                  win_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  if (DEPTH != 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR_WIDTH");
  end
  if (FILTER_SIZE > DEPTH) begin : g_bad_filter
    $error("FILTER_SIZE must not exceed DEPTH");
  end
  if (STRIDE_SIZE > FILTER_SIZE) begin : g_bad_stride
    $error("STRIDE_SIZE must not exceed FILTER_SIZE");
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FILTER_C = (ADDR_WIDTH + 1)'(FILTER_SIZE);
  localparam logic [ADDR_WIDTH:0] STRIDE_C = (ADDR_WIDTH + 1)'(STRIDE_SIZE);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;
  logic [LEN_WIDTH-1:0]  written_q, written_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] tail, head;
  logic                  active, clr, accept, rel_ok, rel_bad, all_written;

  assign active      = (state_q != ST_IDLE);
  assign clr         = (state_q == ST_IDLE) && start_i;
  assign all_written = (written_q == len_q);
  // Ready depends only on registered state so upstream may wait on it before raising valid.
  assign in_ready_o  = (state_q == ST_FILL) && (occ_q < DEPTH_C) && (written_q < len_q);
  assign accept      = in_valid_i && in_ready_o;
  assign rel_ok      = row_done_i && active && (occ_q >= STRIDE_C);
  assign rel_bad     = row_done_i && active && (occ_q < STRIDE_C);

  always_comb begin
    state_d   = state_q;
    occ_d     = occ_q;
    written_d = written_q;
    len_d     = len_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = (total_len_i == '0) ? ST_DRAIN : ST_FILL;
          len_d     = total_len_i;
          occ_d     = '0;
          written_d = '0;
          err_d     = 1'b0;
        end
      end
      ST_FILL:  if (all_written) state_d = ST_DRAIN;
      ST_DRAIN: if (occ_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (accept) begin
      written_d = written_q + LEN_WIDTH'(1);
      occ_d     = occ_d + 1'b1;
    end
    if (rel_ok) begin
      occ_d = occ_d - STRIDE_C;
    end
    if (rel_bad) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      occ_q     <= '0;
      written_q <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      written_q <= written_d;
      len_q     <= len_d;
      err_q     <= err_d;
    end
  end

  if_map_writer_circ_ptr #(.WIDTH(ADDR_WIDTH), .STEP(1)) u_tail (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .inc_i  (accept),
    .ptr_o  (tail)
  );

  if_map_writer_circ_ptr #(.WIDTH(ADDR_WIDTH), .STEP(STRIDE_SIZE)) u_head (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .inc_i  (rel_ok),
    .ptr_o  (head)
  );

  // Write-through: the accepted word reaches the SRAM port in the same cycle.
  assign wen_o       = accept;
  assign waddr_o     = tail;
  assign din_o       = accept ? in_data_i : '0;
  assign chip_en_o   = (state_q == ST_FILL);
  assign head_addr_o = head;
  assign win_ready_o = (occ_q >= FILTER_C) || (all_written && (occ_q != '0));
  assign busy_o      = active;
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_if_map_writer.sv
// tb/tb_if_map_writer.sv - randomized self-checking bench for if_map_writer against a window model
module tb_if_map_writer;

  localparam int AW = 4, DW = 32, LW = 16, DEPTH = 16, FILT = 4, STRIDE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] total_len = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          row_done = 1'b0;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;
  logic          wen, chip_en;
  logic [AW-1:0] head_addr;
  logic          win_ready, busy, done, err;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 filling, 2 draining, 3 finishing; occupancy/head/tail as plain integers.
  int m_ph, m_occ, m_head, m_tail, m_wr, m_len;
  bit m_err;

  always #5 clk = ~clk;

  if_map_writer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .total_len_i(total_len),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .row_done_i(row_done), .waddr_o(waddr), .din_o(din), .wen_o(wen),
    .chip_en_o(chip_en), .head_addr_o(head_addr), .win_ready_o(win_ready),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  function automatic logic [46:0] got_v();
    return {in_ready, wen, waddr, din, chip_en, head_addr, win_ready, busy, done, err};
  endfunction

  function automatic logic [46:0] exp_v();
    logic rdy, acc, wr_win;
    logic [AW-1:0] wa, hd;
    logic [DW-1:0] dd;
    rdy    = (m_ph == 1) && (m_occ < DEPTH) && (m_wr < m_len);
    acc    = rdy && in_valid;
    wa     = AW'(m_tail);
    hd     = AW'(m_head);
    dd     = acc ? in_data : '0;
    wr_win = (m_occ >= FILT) || ((m_wr == m_len) && (m_occ > 0));
    return {rdy, acc, wa, dd, 1'(m_ph == 1), hd, wr_win, 1'(m_ph != 0), 1'(m_ph == 3), m_err};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_occ = 0; m_head = 0; m_tail = 0; m_wr = 0; m_len = 0; m_err = 0;
  endtask

  task automatic set_in(input logic st, input int len, input logic v, input logic rd);
    start = st; total_len = LW'(len); in_valid = v; in_data = $urandom; row_done = rd;
    #1;
  endtask

  task automatic tick();
    bit rdy, acc, rel, bad;
    int ph;
    @(posedge clk);
    rdy = (m_ph == 1) && (m_occ < DEPTH) && (m_wr < m_len);
    acc = rdy && in_valid;
    rel = row_done && (m_ph != 0) && (m_occ >= STRIDE);
    bad = row_done && (m_ph != 0) && (m_occ < STRIDE);
    ph  = m_ph;
    case (m_ph)
      0: if (start) begin
        m_occ = 0; m_head = 0; m_tail = 0; m_wr = 0; m_err = 0; m_len = int'(total_len);
        ph = (total_len == 0) ? 2 : 1;
      end
      1: if (m_wr == m_len) ph = 2;
      2: if (m_occ == 0) ph = 3;
      default: ph = 0;
    endcase
    if (acc) begin m_tail = (m_tail + 1) % DEPTH; m_wr++; m_occ++; end
    if (rel) begin m_head = (m_head + STRIDE) % DEPTH; m_occ -= STRIDE; end
    if (bad) m_err = 1;
    m_ph = ph;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random traffic and releases until the transfer completes; exactly one done pulse expected.
  task automatic finish_transfer(input string name);
    int n = 0;
    int dones = 0;
    while (m_ph != 0 && n < 400) begin
      set_in(0, 0, 1'($urandom_range(0, 1)), (m_occ >= STRIDE) && ($urandom_range(0, 2) != 0));
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL %s outputs got=%h exp=%h", name, got_v(), exp_v());
      end
      if (done) dones++;
      tick();
      n++;
    end
    checks++;
    if (m_ph != 0 || dones != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_done dones=%0d busy=%b exp dones=1 busy=0", name, dones, busy);
    end
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0);
    checks++;
    if (got_v() !== 47'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", got_v());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_in(k == 0, 10, 1, 0);
      if (k == 3) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (got_v() !== 47'd0) begin
          errors++; $display("FAIL reset_midstream got=%h exp=0", got_v());
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        checks++;
        if (got_v() !== exp_v()) begin
          errors++; $display("FAIL reset_prefix outputs got=%h exp=%h", got_v(), exp_v());
        end
        tick();
      end
    end
    set_in(1, 2, 0, 0); tick();
    set_in(0, 0, 1, 0);
    checks++;
    if (wen !== 1'b1 || waddr !== 4'd0 || got_v() !== exp_v()) begin
      errors++; $display("FAIL reset_restart wen=%b waddr=%0d exp wen=1 waddr=0", wen, waddr);
    end
    tick();
    finish_transfer("reset_run");
  endtask

  task automatic test_basic_fill();
    for (int k = 0; k < 6; k++) begin
      set_in(k == 0, 4, 1, 0);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL fill outputs k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (wen !== 1'b1 || waddr !== AW'(k - 1)) begin
          errors++; $display("FAIL fill_addr k=%0d wen=%b waddr=%0d exp wen=1 waddr=%0d", k, wen, waddr, k - 1);
        end
      end
      if (k == 5) begin
        checks++;
        if (win_ready !== 1'b1 || in_ready !== 1'b0) begin
          errors++; $display("FAIL fill_win win_ready=%b in_ready=%b exp 1 0", win_ready, in_ready);
        end
      end
      tick();
    end
    finish_transfer("fill_run");
  endtask

  task automatic test_full_stall();
    for (int k = 0; k < 18; k++) begin
      set_in(k == 0, 20, 1, 0);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL stall outputs k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      tick();
    end
    set_in(0, 0, 1, 1);
    checks++;
    if (in_ready !== 1'b0 || wen !== 1'b0 || win_ready !== 1'b1) begin
      errors++; $display("FAIL stall_full in_ready=%b wen=%b win_ready=%b exp 0 0 1", in_ready, wen, win_ready);
    end
    tick();
    set_in(0, 0, 1, 0);
    checks++;
    if (in_ready !== 1'b1 || wen !== 1'b1 || waddr !== 4'd0 || head_addr !== 4'd2) begin
      errors++; $display("FAIL stall_wrap in_ready=%b wen=%b waddr=%0d head=%0d exp 1 1 0 2",
                         in_ready, wen, waddr, head_addr);
    end
    tick();
    finish_transfer("stall_run");
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 7; k++) begin
      set_in(k == 0, 8, k != 6 || 1'b1, k == 6);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL simul outputs k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      tick();
    end
    set_in(0, 0, 0, 1);
    checks++;
    if (head_addr !== 4'd2 || win_ready !== 1'b1) begin
      errors++; $display("FAIL simul_head head=%0d win_ready=%b exp 2 1", head_addr, win_ready);
    end
    tick();
    set_in(0, 0, 0, 0);
    checks++;
    if (win_ready !== 1'b0 || head_addr !== 4'd4) begin
      errors++; $display("FAIL simul_occ win_ready=%b head=%0d exp 0 4", win_ready, head_addr);
    end
    tick();
    finish_transfer("simul_run");
  endtask

  task automatic test_tail_flush();
    int dones = 0;
    for (int k = 0; k < 10; k++) begin
      set_in(k == 0, 5, k <= 5, k == 7 || k == 9);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL flush outputs k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      tick();
    end
    set_in(0, 0, 0, 1);
    checks++;
    if (win_ready !== 1'b1 || err !== 1'b0 || head_addr !== 4'd4) begin
      errors++; $display("FAIL flush_win win_ready=%b err=%b head=%0d exp 1 0 4", win_ready, err, head_addr);
    end
    tick();
    for (int k = 0; k < 10; k++) begin
      set_in(0, 0, 0, 0);
      if (done) dones++;
      tick();
    end
    checks++;
    if (err !== 1'b1 || win_ready !== 1'b1 || busy !== 1'b1 || head_addr !== 4'd4 || dones != 0) begin
      errors++; $display("FAIL flush_stuck err=%b win=%b busy=%b head=%0d dones=%0d exp 1 1 1 4 0",
                         err, win_ready, busy, head_addr, dones);
    end
    do_reset();
    set_in(1, 6, 0, 0); tick();
    finish_transfer("flush_six");
  endtask

  task automatic test_underflow();
    for (int k = 0; k < 3; k++) begin
      set_in(k == 0, 2, k == 1, k == 2);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL under outputs k=%0d got=%h exp=%h", k, got_v(), exp_v());
      end
      tick();
    end
    set_in(0, 0, 0, 0);
    checks++;
    if (err !== 1'b1 || head_addr !== 4'd0 || win_ready !== 1'b0 || got_v() !== exp_v()) begin
      errors++; $display("FAIL under_err err=%b head=%0d win=%b exp 1 0 0", err, head_addr, win_ready);
    end
    tick();
    finish_transfer("under_run");
    set_in(0, 0, 0, 0);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL under_sticky err=%b exp 1", err);
    end
    set_in(1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL zero_len_a err=%b busy=%b done=%b exp 0 1 0", err, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || got_v() !== exp_v()) begin
      errors++; $display("FAIL zero_len_done done=%b exp 1", done);
    end
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      set_in(1, 2 * $urandom_range(1, 20), 0, 0);
      checks++;
      if (got_v() !== exp_v()) begin
        errors++; $display("FAIL random_start r=%0d got=%h exp=%h", r, got_v(), exp_v());
      end
      tick();
      finish_transfer("random_run");
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_fill();
    test_full_stall();
    test_simultaneous();
    test_tail_flush();
    test_underflow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
